mem_arbiter: RTL and testbench

Two-port arbiter that shares the single 128-bit line-wide data memory between the data cache (refill/write-back) and the instruction cache (refill). Sits between both caches and `datamem`, owning the `mem_req`/`WriteEnable`/`memory_address`/`mem_writedata`/`mem_readdata`/`mem_ready` handshake. It serialises line transactions with round-robin fairness and returns each response to the requester that issued it.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide data memory between the data cache
// (read/write) and the instruction cache (read only).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  output logic                  mem_req,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [LINE_WIDTH-1:0] mem_writedata,
  input  logic [LINE_WIDTH-1:0] mem_readdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_D = 2'd1;
  localparam logic [1:0] SERVE_I = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  logic [1:0]            state;
  logic                  last;
  logic                  owner;
  logic                  weReg;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [LINE_WIDTH-1:0] wdataReg;
  logic [LINE_WIDTH-1:0] dRdataReg;
  logic [LINE_WIDTH-1:0] iRdataReg;
  logic                  grantValid;
  logic                  grantPort;

  // Under contention the port that did not win last time gets the grant.
  always_comb begin
    grantValid = d_req | i_req;
    grantPort  = PORT_D;
    if (d_req && i_req) begin
      grantPort = ~last;
    end else if (i_req) begin
      grantPort = PORT_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= PORT_I;
      owner     <= PORT_D;
      weReg     <= 1'b0;
      addrReg   <= '0;
      wdataReg  <= '0;
      dRdataReg <= '0;
      iRdataReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            last <= grantPort;
            if (grantPort == PORT_I) begin
              addrReg <= i_addr;
              weReg   <= 1'b0;
              state   <= SERVE_I;
            end else begin
              addrReg  <= d_addr;
              wdataReg <= d_wdata;
              weReg    <= d_we;
              state    <= SERVE_D;
            end
          end
        end
        SERVE_D, SERVE_I: begin
          if (mem_ready) begin
            if (!weReg) begin
              if (state == SERVE_I) begin
                iRdataReg <= mem_readdata;
              end else begin
                dRdataReg <= mem_readdata;
              end
            end
            owner <= (state == SERVE_I) ? PORT_I : PORT_D;
            state <= RESP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req        = (state == SERVE_D) || (state == SERVE_I);
  assign WriteEnable    = mem_req & weReg;
  assign memory_address = addrReg;
  assign mem_writedata  = wdataReg;
  assign d_rdata        = dRdataReg;
  assign i_rdata        = iRdataReg;
  assign d_ready        = (state == RESP) && (owner == PORT_D);
  assign i_ready        = (state == RESP) && (owner == PORT_I);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model
// compared every cycle, directed scenarios plus randomized traffic.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_req, d_we, i_req, mem_ready;
  logic [AW-1:0] d_addr, i_addr;
  logic [LW-1:0] d_wdata, mem_readdata;
  logic [LW-1:0] d_rdata, i_rdata, mem_writedata;
  logic          d_ready, i_ready, mem_req, WriteEnable, busy;
  logic [AW-1:0] memory_address;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .mem_req(mem_req), .WriteEnable(WriteEnable), .memory_address(memory_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  // Reference model: one outstanding transaction, described by who owns it,
  // what it carries, and whether memory has already answered.
  bit          mInTxn, mPort, mWe, mDone, mLast;
  logic [AW-1:0] mAddr;
  logic [LW-1:0] mWdata, mDR, mIR;

  task automatic modelReset();
    mInTxn = 0; mPort = 0; mWe = 0; mDone = 0; mLast = 1;
    mAddr = '0; mWdata = '0; mDR = '0; mIR = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelStep();
    if (!mInTxn) begin
      if (d_req || i_req) begin
        mPort  = (d_req && i_req) ? !mLast : i_req;
        mLast  = mPort;
        mInTxn = 1;
        mDone  = 0;
        if (mPort) begin
          mAddr = i_addr;
          mWe   = 0;
        end else begin
          mAddr  = d_addr;
          mWdata = d_wdata;
          mWe    = d_we;
        end
      end
    end else if (!mDone) begin
      if (mem_ready) begin
        mDone = 1;
        if (!mWe) begin
          if (mPort) mIR = mem_readdata;
          else       mDR = mem_readdata;
        end
      end
    end else begin
      mInTxn = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic compareAll();
    bit serving;
    serving = mInTxn && !mDone;
    chk("busy", busy, mInTxn);
    chk("mem_req", mem_req, serving);
    chk("WriteEnable", WriteEnable, serving && mWe);
    chk("d_ready", d_ready, mInTxn && mDone && !mPort);
    chk("i_ready", i_ready, mInTxn && mDone && mPort);
    chk("memory_address", memory_address, mAddr);
    chk("mem_writedata", mem_writedata, mWdata);
    chk("d_rdata", d_rdata, mDR);
    chk("i_rdata", i_rdata, mIR);
  endtask

  task automatic tick();
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleInputs();
    d_req = 0; d_we = 0; i_req = 0; mem_ready = 0;
  endtask

  function automatic logic [LW-1:0] rndLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [LW-1:0] ones11, beef, zeroLine;
  int            order[$];
  bit            dWait, iWait, dDrop, iDrop, dRdyNow, iRdyNow;

  initial begin
    ones11   = {16{8'h11}};
    beef     = {4{32'hDEADBEEF}};
    zeroLine = '0;
    rst = 1;
    idleInputs();
    d_addr = '0; i_addr = '0; d_wdata = '0; mem_readdata = '0;
    modelReset();
    @(negedge clk);
    rst = 0;
    compareAll();
    chk("reset_busy", busy, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_addr", memory_address, 0);
    chk("reset_d_rdata", d_rdata, zeroLine);

    // Single D read, memory answers after two SERVE cycles
    d_req = 1; d_addr = 32'h40;
    tick();
    chk("dread_addr", memory_address, 32'h40);
    chk("dread_we", WriteEnable, 0);
    chk("dread_mem_req", mem_req, 1);
    tick();
    mem_ready = 1; mem_readdata = ones11;
    tick();
    chk("dread_ready", d_ready, 1);
    chk("dread_rdata", d_rdata, ones11);
    chk("dread_i_ready", i_ready, 0);
    idleInputs(); mem_readdata = rndLine();
    tick();
    chk("dread_ready_pulse", d_ready, 0);

    // D write: data must not disturb d_rdata
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = beef;
    tick();
    chk("dwrite_we", WriteEnable, 1);
    chk("dwrite_wdata", mem_writedata, beef);
    mem_ready = 1;
    tick();
    chk("dwrite_ready", d_ready, 1);
    chk("dwrite_we_resp", WriteEnable, 0);
    chk("dwrite_rdata_kept", d_rdata, ones11);
    idleInputs();
    tick();

    // Contention from reset: grants alternate D, I, D, I
    rst = 1; #1; modelReset(); @(negedge clk); rst = 0; compareAll();
    d_req = 1; i_req = 1; d_addr = 32'h100; i_addr = 32'h200; mem_ready = 1;
    order.delete();
    for (int c = 0; c < 12; c++) begin
      mem_readdata = rndLine();
      tick();
      if (d_ready) order.push_back(0);
      if (i_ready) order.push_back(1);
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("grant_order%0d", k), (k < order.size()) ? order[k] : 2, k % 2);
    idleInputs();
    tick(); tick();

    // I request arriving during SERVE_D waits until after D completes
    d_req = 1; d_addr = 32'h300;
    tick();
    i_req = 1; i_addr = 32'h400;
    tick(); tick();
    chk("late_i_addr_hold", memory_address, 32'h300);
    mem_ready = 1; mem_readdata = rndLine();
    tick();
    chk("late_i_d_ready", d_ready, 1);
    chk("late_i_addr_resp", memory_address, 32'h300);
    d_req = 0; mem_ready = 0;
    tick();
    chk("late_i_idle", busy, 0);
    tick();
    chk("late_i_granted", memory_address, 32'h400);

    // Asynchronous reset mid SERVE_I, then D wins first contention
    tick();
    #2 rst = 1;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_busy", busy, 0);
    modelReset();
    @(negedge clk);
    rst = 0;
    compareAll();
    chk("async_no_i_ready", i_ready, 0);
    d_req = 1; d_addr = 32'h500; i_req = 1; i_addr = 32'h600;
    tick();
    chk("after_reset_d_first", memory_address, 32'h500);
    mem_ready = 1;
    tick();
    idleInputs();
    tick(); tick(); tick();

    // Stray mem_ready while idle
    mem_ready = 1;
    tick(); tick();
    chk("stray_busy", busy, 0);
    chk("stray_d_ready", d_ready, 0);
    chk("stray_i_ready", i_ready, 0);
    idleInputs();
    tick();

    // Randomized traffic
    dWait = 0; iWait = 0; dDrop = 0; iDrop = 0;
    for (int c = 0; c < 3000; c++) begin
      dRdyNow = mInTxn && mDone && !mPort;
      iRdyNow = mInTxn && mDone && mPort;
      if (dRdyNow) begin dWait = 0; dDrop = 0; end
      if (iRdyNow) begin iWait = 0; iDrop = 0; end
      if (!dWait && ($urandom % 3 == 0)) begin
        dWait = 1; d_we = $urandom; d_addr = $urandom; d_wdata = rndLine();
      end
      if (!iWait && ($urandom % 3 == 0)) begin
        iWait = 1; i_addr = $urandom;
      end
      // Inputs of a port already in service are don't-care
      if (mInTxn && !mDone && !mPort) begin
        if ($urandom % 8 == 0) dDrop = 1;
        d_addr = $urandom; d_wdata = rndLine(); d_we = $urandom;
      end
      if (mInTxn && !mDone && mPort) begin
        if ($urandom % 8 == 0) iDrop = 1;
        i_addr = $urandom;
      end
      d_req = dWait && !dDrop;
      i_req = iWait && !iDrop;
      mem_ready = ($urandom % 5 < 2);
      mem_readdata = rndLine();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
